// File: rtl/hdp_spi_master_pkg.sv
// HDP SPI master shared definitions: FSM states, frame layout, helpers.
// Used by hdp_spi_master and its clock divider.
package hdp_spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_DONE     = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

    localparam int   FRAME_BITS = 16;
    localparam logic RW_READ    = 1'b1;
    localparam logic RW_WRITE   = 1'b0;

    // Frame image: R/W bit, 7-bit address, then data (zeros for a read).
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic       rw,
        input logic [6:0] addr,
        input logic [7:0] data
    );
        return {rw, addr, (rw == RW_READ) ? 8'h00 : data};
    endfunction

endpackage

// File: rtl/hdp_spi_master_spi_clk_div.sv
// SCK phase counter for the HDP SPI master.
// Emits a rise strike at the end of each low half and a fall strike at the end of each high half.
module hdp_spi_master_spi_clk_div #(
    parameter int CLOCKS_PER_BIT = 4
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_run,
    output logic o_rise,
    output logic o_fall
);

    localparam int H  = CLOCKS_PER_BIT / 2;
    localparam int CW = $clog2(CLOCKS_PER_BIT);

    localparam logic [CW-1:0] LP_RISE = CW'(H - 1);
    localparam logic [CW-1:0] LP_FALL = CW'(CLOCKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    // Phase counter restarts whenever the frame engine is not running.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (!i_run || (r_cnt == LP_FALL)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_rise = i_run && (r_cnt == LP_RISE);
    assign o_fall = i_run && (r_cnt == LP_FALL);

endmodule

// File: rtl/hdp_spi_master.sv
// Single-register SPI master for the HDP display controller (16-bit CS-framed transfers).
// Optional macro HDP_SPI_GAP_EN inserts a CS_GAP_CLKS-cycle idle gap after every frame.
module hdp_spi_master
    import hdp_spi_master_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 4,
    parameter int CS_GAP_CLKS    = 8
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_txBegin,
    input  logic [6:0] i_txAddress,
    input  logic [7:0] i_txData,
    output logic       o_txBusy,
    output logic       o_txDone,
    input  logic       i_rxBegin,
    input  logic [6:0] i_rxAddress,
    output logic [7:0] o_rxData,
    output logic       o_rxBusy,
    output logic       o_rxDone,
    input  logic       i_sout,
    output logic       o_sen,
    output logic       o_sck,
    output logic       o_sdat
);

    state_t r_state;
    state_t w_next;

    logic                  r_is_read;
    logic                  r_sen;
    logic                  r_sck;
    logic [FRAME_BITS-1:0] r_shift;
    logic [3:0]            r_bit;
    logic [7:0]            r_rx_sh;
    logic [7:0]            r_rxData;

    logic w_run;
    logic w_rise;
    logic w_fall;
    logic w_accept;
    logic w_busy;
    logic w_gap_end;

    assign w_run = (r_state == ST_CS_SETUP) ||
                   (r_state == ST_SHIFT) ||
                   (r_state == ST_CS_HOLD);

    hdp_spi_master_spi_clk_div #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_clk_div (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_run    (w_run),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

`ifdef HDP_SPI_GAP_EN
    localparam int GW = $clog2(CS_GAP_CLKS + 1);

    logic [GW-1:0] r_gap;

    // Counts cycles spent in GAP; cleared on any other state.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_gap <= '0;
        end else if (r_state == ST_GAP) begin
            r_gap <= r_gap + 1'b1;
        end else begin
            r_gap <= '0;
        end
    end

    assign w_gap_end = (r_gap == GW'(CS_GAP_CLKS - 1));
`else
    assign w_gap_end = 1'b1;
`endif

    // State register.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; requests are only looked at in IDLE.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_txBegin || i_rxBegin) begin
                    w_next   = ST_CS_SETUP;
                    w_accept = 1'b1;
                end
            end
            ST_CS_SETUP: begin
                if (w_rise) begin
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_rise && (r_bit == 4'd15)) begin
                    w_next = ST_CS_HOLD;
                end
            end
            ST_CS_HOLD: begin
                if (w_fall) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
`ifdef HDP_SPI_GAP_EN
                w_next = ST_GAP;
`else
                w_next = ST_IDLE;
`endif
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: load on accept, shift on SCK fall, sample on SCK rise.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_is_read <= 1'b0;
            r_sen     <= 1'b1;
            r_sck     <= 1'b0;
            r_shift   <= '0;
            r_bit     <= '0;
            r_rx_sh   <= '0;
            r_rxData  <= '0;
        end else begin
            if (w_accept) begin
                r_is_read <= !i_txBegin;
                r_sen     <= 1'b0;
                r_bit     <= '0;
                if (i_txBegin) begin
                    r_shift <= build_frame(RW_WRITE, i_txAddress, i_txData);
                end else begin
                    r_shift <= build_frame(RW_READ, i_rxAddress, 8'h00);
                end
            end
            if ((r_state == ST_CS_SETUP) && w_rise) begin
                r_sck   <= 1'b1;
                r_rx_sh <= {r_rx_sh[6:0], i_sout};
            end
            if (r_state == ST_SHIFT) begin
                if (w_fall) begin
                    r_sck   <= 1'b0;
                    r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                end
                if (w_rise) begin
                    if (r_bit == 4'd15) begin
                        r_bit <= '0;
                    end else begin
                        r_bit   <= r_bit + 1'b1;
                        r_sck   <= 1'b1;
                        r_rx_sh <= {r_rx_sh[6:0], i_sout};
                    end
                end
            end
            if ((r_state == ST_CS_HOLD) && w_fall) begin
                r_sen <= 1'b1;
                if (r_is_read) begin
                    r_rxData <= r_rx_sh;
                end
            end
        end
    end

    assign w_busy = (r_state == ST_CS_SETUP) ||
                    (r_state == ST_SHIFT) ||
                    (r_state == ST_CS_HOLD) ||
                    (r_state == ST_DONE);

    assign o_txBusy = w_busy && !r_is_read;
    assign o_rxBusy = w_busy && r_is_read;
    assign o_txDone = (r_state == ST_DONE) && !r_is_read;
    assign o_rxDone = (r_state == ST_DONE) && r_is_read;
    assign o_rxData = r_rxData;
    assign o_sen    = r_sen;
    assign o_sck    = r_sck;
    assign o_sdat   = r_shift[FRAME_BITS-1];

endmodule

// File: tb/tb_hdp_spi_master.sv
// Self-checking bench for hdp_spi_master (CLOCKS_PER_BIT=4).
// Honours HDP_SPI_GAP_EN when the design is built with it.
module tb_hdp_spi_master;

    localparam int CPB = 4;
    localparam int H   = CPB / 2;
    localparam int LAT = 2 * H + 16 * CPB + 1;
`ifdef HDP_SPI_GAP_EN
    localparam int GAPW = 8;
`else
    localparam int GAPW = 0;
`endif
    localparam int PERIOD = LAT + 1 + GAPW;

    logic       clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_txBegin = 1'b0;
    logic [6:0] i_txAddress = '0;
    logic [7:0] i_txData = '0;
    logic       i_rxBegin = 1'b0;
    logic [6:0] i_rxAddress = '0;
    logic       i_sout = 1'b0;
    logic       o_txBusy, o_txDone, o_rxBusy, o_rxDone;
    logic [7:0] o_rxData;
    logic       o_sen, o_sck, o_sdat;

    hdp_spi_master #(
        .CLOCKS_PER_BIT(CPB),
        .CS_GAP_CLKS   (8)
    ) dut (
        .i_clock    (clk),
        .i_reset_n  (i_reset_n),
        .i_txBegin  (i_txBegin),
        .i_txAddress(i_txAddress),
        .i_txData   (i_txData),
        .o_txBusy   (o_txBusy),
        .o_txDone   (o_txDone),
        .i_rxBegin  (i_rxBegin),
        .i_rxAddress(i_rxAddress),
        .o_rxData   (o_rxData),
        .o_rxBusy   (o_rxBusy),
        .o_rxDone   (o_rxDone),
        .i_sout     (i_sout),
        .o_sen      (o_sen),
        .o_sck      (o_sck),
        .o_sdat     (o_sdat)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;

    // Edge monitor: counters and sdat-stability tracking.
    logic p_sen = 1'b1, p_sck = 1'b0, p_sdat = 1'b0, p_rst = 1'b0;
    int   sdat_viol = 0;
    int   n_txd = 0, n_rxd = 0, n_txb = 0, n_rxb = 0;
    int   acc_q[$];

    always @(posedge clk) begin
        if (p_rst && (o_sdat !== p_sdat) &&
            !(p_sck && !o_sck) && !(p_sen && !o_sen))
            sdat_viol++;
        if (p_sen && !o_sen) acc_q.push_back(cyc);
        if (o_txDone) n_txd++;
        if (o_rxDone) n_rxd++;
        if (o_txBusy) n_txb++;
        if (o_rxBusy) n_rxb++;
        p_sen  = o_sen;
        p_sck  = o_sck;
        p_sdat = o_sdat;
        p_rst  = i_reset_n;
        cyc++;
    end

    // HDP side: capture MOSI on SCK rise, drive MISO after SCK fall.
    logic [15:0] cap = '0;
    int          rcnt = 0;
    logic [7:0]  sout_val = '0;

    always @(posedge o_sck or negedge o_sen) begin
        if (o_sck) begin
            cap = {cap[14:0], o_sdat};
            rcnt++;
        end else begin
            cap  = '0;
            rcnt = 0;
        end
    end

    always @(negedge o_sck) begin
        if (rcnt >= 8 && rcnt <= 15)
            i_sout = sout_val[3'(15 - rcnt)];
        else
            i_sout = 1'b0;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run(input string nm, input bit tx, input bit rx,
                       input logic [6:0] ta, input logic [7:0] td,
                       input logic [6:0] ra, input logic [7:0] sv,
                       input logic [15:0] ef, input logic [7:0] er);
        int a, d, txd0, rxd0, txb0, rxb0;
        bit seen;
        sout_val = sv;
        txd0 = n_txd; rxd0 = n_rxd; txb0 = n_txb; rxb0 = n_rxb;
        @(negedge clk);
        i_txBegin = tx; i_rxBegin = rx;
        i_txAddress = ta; i_txData = td; i_rxAddress = ra;
        @(negedge clk);
        i_txBegin = 1'b0; i_rxBegin = 1'b0;
        a = cyc;
        chk({nm, " txBusy@acc"}, 32'(o_txBusy), 32'(tx));
        chk({nm, " rxBusy@acc"}, 32'(o_rxBusy), 32'(!tx));
        chk({nm, " sen@acc"}, 32'(o_sen), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (o_txDone || o_rxDone) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            nchk++; nerr++;
            $display("FAIL %s timeout: no done pulse within 200 cycles", nm);
        end else begin
            d = cyc;
            chk({nm, " latency"}, 32'(d - a + 1), 32'(LAT));
            chk({nm, " txDone"}, 32'(o_txDone), 32'(tx));
            chk({nm, " rxDone"}, 32'(o_rxDone), 32'(!tx));
            chk({nm, " busy@done"}, 32'(tx ? o_txBusy : o_rxBusy), 32'd1);
            chk({nm, " sen@done"}, 32'(o_sen), 32'd1);
            chk({nm, " rxData"}, 32'(o_rxData), 32'(er));
            chk({nm, " frame"}, 32'(cap), 32'(ef));
            chk({nm, " rises"}, 32'(rcnt), 32'd16);
        end
        @(negedge clk);
        chk({nm, " done pulse width"}, 32'({o_txDone, o_rxDone}), 32'd0);
        repeat (GAPW + 1) @(negedge clk);
        if (tx) begin
            chk({nm, " no rxBusy"}, 32'(n_rxb - rxb0), 32'd0);
            chk({nm, " tx done count"}, 32'(n_txd - txd0), 32'd1);
            chk({nm, " rx done count"}, 32'(n_rxd - rxd0), 32'd0);
        end else begin
            chk({nm, " no txBusy"}, 32'(n_txb - txb0), 32'd0);
            chk({nm, " rx done count"}, 32'(n_rxd - rxd0), 32'd1);
            chk({nm, " tx done count"}, 32'(n_txd - txd0), 32'd0);
        end
    endtask

    typedef struct {
        bit         tx;
        bit         rx;
        logic [6:0] ta;
        logic [7:0] td;
        logic [6:0] ra;
        logic [7:0] sv;
        logic [15:0] frame;
        logic [7:0] rx_exp;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  model_rx;
        logic [15:0] ef;
        int          kind, txd0, q0, nacc;
        logic [6:0]  ta, ra;
        logic [7:0]  td, sv;
        bit          reached;

        tbl[0] = '{1'b1, 1'b0, 7'h09, 8'h19, 7'h00, 8'h00, 16'h0919, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 7'h00, 8'h00, 7'h78, 8'h20, 16'hF800, 8'h20};
        tbl[2] = '{1'b1, 1'b1, 7'h12, 8'h34, 7'h55, 8'hAA, 16'h1234, 8'h20};
        tbl[3] = '{1'b0, 1'b1, 7'h00, 8'h00, 7'h00, 8'hFF, 16'h8000, 8'hFF};

        repeat (3) @(negedge clk);
        chk("reset sen", 32'(o_sen), 32'd1);
        chk("reset sck", 32'(o_sck), 32'd0);
        chk("reset sdat", 32'(o_sdat), 32'd0);
        chk("reset busy/done",
            32'({o_txBusy, o_txDone, o_rxBusy, o_rxDone}), 32'd0);
        chk("reset rxData", 32'(o_rxData), 32'd0);
        i_reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++)
            run($sformatf("vec%0d", i), tbl[i].tx, tbl[i].rx, tbl[i].ta,
                tbl[i].td, tbl[i].ra, tbl[i].sv, tbl[i].frame, tbl[i].rx_exp);

        // Reset in the middle of a write, during SCK bit 5.
        txd0 = n_txd;
        @(negedge clk);
        i_txBegin = 1'b1; i_txAddress = 7'h2A; i_txData = 8'h55;
        @(negedge clk);
        i_txBegin = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rcnt == 6) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!reached) begin
            nchk++; nerr++;
            $display("FAIL midreset: SCK bit 5 not reached, rises=%0d", rcnt);
        end
        i_reset_n = 1'b0;
        @(negedge clk);
        chk("midreset sen", 32'(o_sen), 32'd1);
        chk("midreset sck", 32'(o_sck), 32'd0);
        chk("midreset sdat", 32'(o_sdat), 32'd0);
        chk("midreset busy", 32'({o_txBusy, o_rxBusy}), 32'd0);
        i_reset_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("midreset no done", 32'(n_txd - txd0), 32'd0);
        chk("midreset rxData", 32'(o_rxData), 32'd0);
        run("post_reset", 1'b1, 1'b0, 7'h2A, 8'h55, 7'h00, 8'h00,
            16'h2A55, 8'h00);
        model_rx = 8'h00;

        // Begin held high: one frame per IDLE visit at a fixed cadence.
        q0 = acc_q.size();
        txd0 = n_txd;
        @(negedge clk);
        i_txBegin = 1'b1; i_txAddress = 7'h11; i_txData = 8'h22;
        repeat (3 * PERIOD + 5) @(negedge clk);
        i_txBegin = 1'b0;
        repeat (PERIOD + 5) @(negedge clk);
        nacc = acc_q.size() - q0;
        chk("held accepts", 32'(nacc), 32'd4);
        chk("held dones", 32'(n_txd - txd0), 32'(nacc));
        for (int i = 1; i < nacc; i++)
            chk($sformatf("held period%0d", i),
                32'(acc_q[q0 + i] - acc_q[q0 + i - 1]), 32'(PERIOD));
        chk("held frame", 32'(cap), 32'h1122);

        // Random requests against a frame-level reference model.
        for (int n = 0; n < 16; n++) begin
            kind = int'($urandom_range(0, 2));
            ta = 7'($urandom); td = 8'($urandom);
            ra = 7'($urandom); sv = 8'($urandom);
            if (kind == 1) begin
                ef = 16'(32768 + int'(ra) * 256);
                model_rx = sv;
            end else begin
                ef = 16'(int'(ta) * 256 + int'(td));
            end
            run($sformatf("rand%0d", n), kind != 1, kind != 0,
                ta, td, ra, sv, ef, model_rx);
        end

        chk("sdat only on SCK fall", 32'(sdat_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
